// File: rtl/scanner_rx.sv
// -----------------------------------------------------------------------------
// scanner_rx
//   Receives framed serial traffic from a scanner peripheral. Bits arrive MSB
//   first on dataIn, qualified by rising edges of clkIn. Both lines are
//   asynchronous to clk, so each is double-flop synchronized before use.
//
//   A frame is one command byte. The data command (NCMD_DATA) is followed by
//   one data byte. Command codes 2, 3 and 4 update sticky peer status flags.
//   A partial frame with no clkIn edge for TIMEOUT clk cycles is aborted.
//
// Ports
//   clk          system clock, all state on its rising edge
//   rst          asynchronous active-low reset
//   clkIn        serial bit clock from the scanner (asynchronous)
//   dataIn       serial data, sampled at clkIn rising edge (asynchronous)
//   dataAck      consumer accepts the held data byte
//   cmdValid     one-cycle pulse, command byte complete
//   cmdCode      last received command byte
//   dataValid    level, dataByte holds unconsumed data
//   dataByte     last received data byte
//   peerReady    sticky, set by command 2, cleared by a data byte
//   peerScanning sticky, set by command 3, cleared by command 4
//   peerFull     sticky, set by command 4, cleared by a data byte
//   frameErr     one-cycle pulse, timeout abort or unknown command
//   overrun      sticky, data byte arrived while previous one unconsumed
// -----------------------------------------------------------------------------
module scanner_rx #(
  parameter int          TIMEOUT   = 16,
  parameter logic [7:0]  NCMD_DATA = 8'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkIn,
  input  logic       dataIn,
  input  logic       dataAck,
  output logic       cmdValid,
  output logic [7:0] cmdCode,
  output logic       dataValid,
  output logic [7:0] dataByte,
  output logic       peerReady,
  output logic       peerScanning,
  output logic       peerFull,
  output logic       frameErr,
  output logic       overrun
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers and edge detect (stage p0)
  // ---------------------------------------------------------------------------
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_edge_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1   <= 1'b0;
      r_clk_s2   <= 1'b0;
      r_clk_prev <= 1'b0;
      r_dat_s1   <= 1'b0;
      r_dat_s2   <= 1'b0;
    end else begin
      r_clk_s1   <= clkIn;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= dataIn;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_edge_p0 = r_clk_s2 & ~r_clk_prev;

  // ---------------------------------------------------------------------------
  // Registered edge and its data bit (stage p1)
  // ---------------------------------------------------------------------------
  // The data bit is carried alongside the edge strobe so both stay aligned.
  logic r_edge_p1;
  logic r_dat_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge_p1 <= 1'b0;
      r_dat_p1  <= 1'b0;
    end else begin
      r_edge_p1 <= w_edge_p0;
      r_dat_p1  <= r_dat_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift register, bit counter, idle counter
  // ---------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic [IW-1:0]   r_idle;
  logic [7:0]      w_byte;
  logic            w_done;
  logic            w_timeout;

  assign w_byte    = {r_shift[6:0], r_dat_p1};
  // The counter is zero whenever a frame starts, so the 8th edge is cnt==7.
  assign w_done    = r_edge_p1 && (r_bitcnt == 3'd7);
  assign w_timeout = (r_state != S_IDLE) && !r_edge_p1 &&
                     (r_idle == IW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift  <= 8'h00;
      r_bitcnt <= 3'd0;
    end else if (w_timeout) begin
      r_shift  <= 8'h00;
      r_bitcnt <= 3'd0;
    end else if (r_edge_p1) begin
      r_shift  <= w_byte;
      r_bitcnt <= r_bitcnt + 3'd1;
    end
  end

  // Counts cycles since the last edge while a frame is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
    end else if ((r_state == S_IDLE) || r_edge_p1 || w_timeout) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  logic w_cmd_done;
  logic w_data_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_done  = 1'b0;
    w_data_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The first edge of a frame is shifted in as bit 7.
        if (r_edge_p1) begin
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        if (w_done) begin
          w_cmd_done  = 1'b1;
          w_state_nxt = (w_byte == NCMD_DATA) ? S_DATA : S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_done) begin
          w_data_done = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers (stage p2)
  // ---------------------------------------------------------------------------
  logic       r_cmd_vld_p2;
  logic [7:0] r_cmd_code_p2;
  logic       r_data_vld_p2;
  logic [7:0] r_data_byte_p2;
  logic       r_ready;
  logic       r_scanning;
  logic       r_full;
  logic       r_frame_err_p2;
  logic       r_overrun;
  logic       w_known_cmd;

  // Codes that are accepted without raising a frame error.
  assign w_known_cmd = (w_byte == NCMD_DATA) || (w_byte == 8'd2) ||
                       (w_byte == 8'd3)      || (w_byte == 8'd4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_vld_p2   <= 1'b0;
      r_cmd_code_p2  <= 8'h00;
      r_data_vld_p2  <= 1'b0;
      r_data_byte_p2 <= 8'h00;
      r_ready        <= 1'b0;
      r_scanning     <= 1'b0;
      r_full         <= 1'b0;
      r_frame_err_p2 <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_cmd_vld_p2   <= 1'b0;
      r_frame_err_p2 <= 1'b0;

      if (w_timeout) begin
        r_frame_err_p2 <= 1'b1;
      end

      if (w_cmd_done) begin
        r_cmd_vld_p2  <= 1'b1;
        r_cmd_code_p2 <= w_byte;
        if (!w_known_cmd) begin
          r_frame_err_p2 <= 1'b1;
        end else if (w_byte != NCMD_DATA) begin
          case (w_byte)
            8'd2: r_ready <= 1'b1;
            8'd3: r_scanning <= 1'b1;
            8'd4: begin
              r_full     <= 1'b1;
              r_scanning <= 1'b0;
            end
            default: ;
          endcase
        end
      end

      if (w_data_done) begin
        // A new byte always overwrites; an unacknowledged held byte is lost.
        r_data_byte_p2 <= w_byte;
        r_data_vld_p2  <= 1'b1;
        r_ready        <= 1'b0;
        r_full         <= 1'b0;
        if (r_data_vld_p2 && !dataAck) begin
          r_overrun <= 1'b1;
        end
      end else if (r_data_vld_p2 && dataAck) begin
        r_data_vld_p2 <= 1'b0;
      end
    end
  end

  assign cmdValid     = r_cmd_vld_p2;
  assign cmdCode      = r_cmd_code_p2;
  assign dataValid    = r_data_vld_p2;
  assign dataByte     = r_data_byte_p2;
  assign peerReady    = r_ready;
  assign peerScanning = r_scanning;
  assign peerFull     = r_full;
  assign frameErr     = r_frame_err_p2;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_scanner_rx.sv
module tb_scanner_rx;

  logic       clk;
  logic       rst;
  logic       clkIn;
  logic       dataIn;
  logic       dataAck;
  logic       cmdValid;
  logic [7:0] cmdCode;
  logic       dataValid;
  logic [7:0] dataByte;
  logic       peerReady;
  logic       peerScanning;
  logic       peerFull;
  logic       frameErr;
  logic       overrun;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cv_cnt   = 0;
  int fe_cnt   = 0;

  scanner_rx #(.TIMEOUT(16), .NCMD_DATA(8'd7)) dut (
    .clk          (clk),
    .rst          (rst),
    .clkIn        (clkIn),
    .dataIn       (dataIn),
    .dataAck      (dataAck),
    .cmdValid     (cmdValid),
    .cmdCode      (cmdCode),
    .dataValid    (dataValid),
    .dataByte     (dataByte),
    .peerReady    (peerReady),
    .peerScanning (peerScanning),
    .peerFull     (peerFull),
    .frameErr     (frameErr),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (cmdValid === 1'b1) cv_cnt++;
    if (frameErr === 1'b1) fe_cnt++;
  end

  // Send the top n bits of b, MSB first. Returns 2 cycles after the last rise,
  // with clkIn still high.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      dataIn = b[i];
      clkIn  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clkIn = 1'b1;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b0;
    clkIn   = 1'b0;
    dataIn  = 1'b0;
    dataAck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; clkIn = 1'b0; dataIn = 1'b0; dataAck = 1'b0;
    repeat (3) @(negedge clk);
    tot_cnt++; if ({cmdValid, dataValid, peerReady, peerScanning, peerFull, frameErr, overrun} !== 7'b0)
      $display("FAIL reset_flags got %b exp 0000000", {cmdValid, dataValid, peerReady, peerScanning, peerFull, frameErr, overrun});
    else pass_cnt++;
    tot_cnt++; if ({cmdCode, dataByte} !== 16'h0000)
      $display("FAIL reset_bytes got %h exp 0000", {cmdCode, dataByte});
    else pass_cnt++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmd02();
    int cv0, fe0;
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_byte(8'h02);
    @(negedge clk);
    tot_cnt++; if (cmdValid !== 1'b0) $display("FAIL cmd02_early got %b exp 0", cmdValid);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (cmdValid !== 1'b1) $display("FAIL cmd02_latency got %b exp 1", cmdValid);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    tot_cnt++; if (cv_cnt - cv0 !== 1) $display("FAIL cmd02_pulses got %0d exp 1", cv_cnt - cv0);
    else pass_cnt++;
    tot_cnt++; if (cmdCode !== 8'h02) $display("FAIL cmd02_code got %h exp 02", cmdCode);
    else pass_cnt++;
    tot_cnt++; if ({peerReady, dataValid} !== 2'b10) $display("FAIL cmd02_flags got %b exp 10", {peerReady, dataValid});
    else pass_cnt++;
    tot_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL cmd02_ferr got %0d exp 0", fe_cnt - fe0);
    else pass_cnt++;
  endtask

  task automatic test_data();
    send_byte(8'h07);
    @(negedge clk);
    @(negedge clk);
    tot_cnt++; if ({cmdValid, cmdCode} !== {1'b1, 8'h07}) $display("FAIL data_cmd got %b/%h exp 1/07", cmdValid, cmdCode);
    else pass_cnt++;
    send_byte(8'hA5);
    @(negedge clk);
    tot_cnt++; if (dataValid !== 1'b0) $display("FAIL data_early got %b exp 0", dataValid);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if ({dataValid, dataByte, peerReady} !== {1'b1, 8'hA5, 1'b0})
      $display("FAIL data_byte got %b/%h/%b exp 1/a5/0", dataValid, dataByte, peerReady);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    tot_cnt++; if (dataValid !== 1'b1) $display("FAIL data_hold got %b exp 1", dataValid);
    else pass_cnt++;
    dataAck = 1'b1;
    @(negedge clk);
    dataAck = 1'b0;
    tot_cnt++; if (dataValid !== 1'b0) $display("FAIL data_ack got %b exp 0", dataValid);
    else pass_cnt++;
  endtask

  task automatic test_flags();
    int fe0;
    send_byte(8'h03);
    repeat (4) @(negedge clk);
    tot_cnt++; if ({peerReady, peerScanning, peerFull} !== 3'b010) $display("FAIL flags_03 got %b exp 010", {peerReady, peerScanning, peerFull});
    else pass_cnt++;
    send_byte(8'h04);
    repeat (4) @(negedge clk);
    tot_cnt++; if ({peerReady, peerScanning, peerFull} !== 3'b001) $display("FAIL flags_04 got %b exp 001", {peerReady, peerScanning, peerFull});
    else pass_cnt++;
    fe0 = fe_cnt;
    send_byte(8'h09);
    @(negedge clk);
    @(negedge clk);
    tot_cnt++; if ({cmdValid, frameErr, cmdCode} !== {2'b11, 8'h09}) $display("FAIL flags_09 got %b%b/%h exp 11/09", cmdValid, frameErr, cmdCode);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    tot_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL flags_09_ferr got %0d exp 1", fe_cnt - fe0);
    else pass_cnt++;
    tot_cnt++; if ({peerReady, peerScanning, peerFull} !== 3'b001) $display("FAIL flags_09_keep got %b exp 001", {peerReady, peerScanning, peerFull});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int cv0, fe0;
    fe0 = fe_cnt;
    repeat (30) @(negedge clk);
    tot_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL to_idle got %0d exp 0", fe_cnt - fe0);
    else pass_cnt++;
    cv0 = cv_cnt;
    send_bits(8'hE0, 3);
    @(negedge clk);
    clkIn = 1'b0;
    repeat (8) @(negedge clk);
    tot_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL to_early got %0d exp 0", fe_cnt - fe0);
    else pass_cnt++;
    repeat (15) @(negedge clk);
    tot_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL to_abort got %0d exp 1", fe_cnt - fe0);
    else pass_cnt++;
    tot_cnt++; if ({cv_cnt - cv0, dataValid} !== {32'd0, 1'b0}) $display("FAIL to_noout got %0d/%b exp 0/0", cv_cnt - cv0, dataValid);
    else pass_cnt++;
    send_byte(8'h02);
    repeat (4) @(negedge clk);
    tot_cnt++; if ({cv_cnt - cv0, cmdCode, fe_cnt - fe0} !== {32'd1, 8'h02, 32'd1})
      $display("FAIL to_recover got %0d/%h/%0d exp 1/02/1", cv_cnt - cv0, cmdCode, fe_cnt - fe0);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    send_byte(8'h07); repeat (2) @(negedge clk);
    send_byte(8'h5A); repeat (2) @(negedge clk);
    tot_cnt++; if ({dataValid, overrun} !== 2'b10) $display("FAIL ovr_first got %b exp 10", {dataValid, overrun});
    else pass_cnt++;
    send_byte(8'h07); repeat (2) @(negedge clk);
    send_byte(8'h3C); repeat (2) @(negedge clk);
    tot_cnt++; if ({overrun, dataValid, dataByte} !== {2'b11, 8'h3C}) $display("FAIL ovr_set got %b%b/%h exp 11/3c", overrun, dataValid, dataByte);
    else pass_cnt++;
    dataAck = 1'b1; @(negedge clk); dataAck = 1'b0;
    repeat (30) @(negedge clk);
    tot_cnt++; if ({overrun, dataValid} !== 2'b10) $display("FAIL ovr_sticky got %b exp 10", {overrun, dataValid});
    else pass_cnt++;
    apply_reset();
    send_byte(8'h07); repeat (2) @(negedge clk);
    send_byte(8'h11); repeat (2) @(negedge clk);
    send_byte(8'h07); repeat (2) @(negedge clk);
    send_byte(8'h22);
    @(negedge clk);
    dataAck = 1'b1;
    @(negedge clk);
    dataAck = 1'b0;
    tot_cnt++; if ({overrun, dataValid, dataByte} !== {2'b01, 8'h22}) $display("FAIL ovr_ack got %b%b/%h exp 01/22", overrun, dataValid, dataByte);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h02);
    repeat (4) @(negedge clk);
    tot_cnt++; if ({peerReady, dataValid, cmdCode} !== {2'b11, 8'h02}) $display("FAIL mid_pre got %b%b/%h exp 11/02", peerReady, dataValid, cmdCode);
    else pass_cnt++;
    send_bits(8'h07, 5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tot_cnt++; if ({cmdValid, dataValid, peerReady, peerScanning, peerFull, frameErr, overrun, cmdCode, dataByte} !== 23'd0)
      $display("FAIL mid_reset got %b%b%b%b%b%b%b/%h/%h exp 0", cmdValid, dataValid, peerReady, peerScanning, peerFull, frameErr, overrun, cmdCode, dataByte);
    else pass_cnt++;
    clkIn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h02);
    repeat (4) @(negedge clk);
    tot_cnt++; if ({cmdCode, peerReady, frameErr} !== {8'h02, 2'b10}) $display("FAIL mid_after got %h/%b%b exp 02/10", cmdCode, peerReady, frameErr);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cmd02();
    test_data();
    test_flags();
    test_timeout();
    test_overrun();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/scanner_rx.md
SCANNER_RX -- requirements
Module: scanner_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: clk cycles with no clkIn rising edge before a partial frame is aborted.
REQ-002 SHALL have parameter NCMD_DATA, default 8'd7: command code that is followed by one data byte.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 clkIn  input  1  serial bit clock from the scanner, asynchronous to clk.
REQ-006 dataIn  input  1  serial data, MSB first, valid at clkIn rising edge.
REQ-007 dataAck  input  1  consumer accepts the held data byte.
REQ-008 cmdValid  output  1  one-cycle pulse: command byte complete.
REQ-009 cmdCode  output  8  last received command byte, held until the next command.
REQ-010 dataValid  output  1  level: dataByte holds unconsumed data.
REQ-011 dataByte  output  8  received data byte.
REQ-012 peerReady, peerScanning, peerFull  output  1 each  sticky status from commands 2, 3 and 4.
REQ-013 frameErr  output  1  one-cycle pulse: timeout abort or unknown command.
REQ-014 overrun  output  1  sticky: data byte arrived while dataValid=1.

Function
REQ-015 clkIn and dataIn SHALL each pass through a 2-flop synchronizer; a rising edge is detected on synced clkIn=1 with its previous registered value=0.
REQ-016 On each detected edge, synced dataIn SHALL be shifted into an 8-bit shift register LSB end (MSB first on the wire), and a 3-bit bit counter SHALL increment.
REQ-017 The 8th edge (counter wraps 7->0) SHALL complete a byte; completion is registered and seen on outputs the next cycle.
REQ-018 FSM states: IDLE, CMD, DATA.
REQ-019 IDLE -> CMD on the first detected edge, which is shifted as bit 7.
REQ-020 CMD byte complete: cmdCode <= byte and cmdValid pulses for 1 cycle. If byte==NCMD_DATA, go to DATA; otherwise go to IDLE.
REQ-021 Command decode in CMD: 2 sets peerReady; 3 sets peerScanning; 4 sets peerFull and clears peerScanning; 7 sets no flag. Any other code pulses frameErr with cmdValid.
REQ-022 DATA byte complete: dataByte <= byte, dataValid <= 1, next state IDLE. If dataValid was already 1 and dataAck=0 that cycle, set overrun; the new byte still overwrites.
REQ-023 dataValid SHALL clear the cycle after dataAck=1 when dataValid=1. Simultaneous dataAck and data completion: the new byte loads, dataValid stays 1, no overrun.
REQ-024 Receiving data (byte complete in DATA) SHALL clear peerReady and peerFull.
REQ-025 An idle counter SHALL run in CMD/DATA, clearing on every edge. At TIMEOUT: pulse frameErr, clear the bit counter and shift register, go to IDLE. No cmdValid or dataValid is produced.
REQ-026 The idle counter SHALL hold at 0 in IDLE; TIMEOUT SHALL never trigger in IDLE.
REQ-027 clkIn high and low phases SHALL each be at least 2 clk periods; shorter pulses are out of scope.
REQ-028 Latency: clkIn rising edge to edge detect is 3 clk cycles; 8th edge detect to cmdValid/dataValid is 1 cycle.
REQ-029 overrun SHALL be cleared only by reset.

Reset
REQ-030 When rst=0 (asynchronous): FSM=IDLE, synchronizers/shift/counters=0, cmdCode=dataByte=8'h00, all 1-bit outputs=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial byte; after release the next edge starts a new frame as bit 7.

Verification
REQ-032 Serial 8'h02 -> one cmdValid pulse, cmdCode=02, peerReady=1, dataValid=0, FSM back in IDLE.
REQ-033 Serial 8'h07 then 8'hA5 -> cmdValid with cmdCode=07; 4 cycles after the 16th edge, dataValid=1, dataByte=A5, peerReady=0; after dataAck, dataValid=0.
REQ-034 Send 8'h03 then 8'h04 -> peerScanning 1 then 0, peerFull=1; then send 8'h09 -> frameErr pulse and cmdValid, flags unchanged.
REQ-035 Send 3 bits, then hold clkIn low for 17 cycles -> frameErr at cycle TIMEOUT; next full 8'h02 decodes correctly.
REQ-036 Two 07+data frames with no dataAck -> overrun=1, dataByte equals the second byte; repeat with dataAck on the completion cycle -> overrun stays 0.
REQ-037 Pull rst low after 5 bits of 8'h07 -> all outputs 0 immediately; after release, 8'h02 decodes to cmdCode=02.
